intersection_controller: RTL and testbench
==========================================

# intersection_controller

Central sequencer for one two-approach intersection (north-south and east-west). It drives both approach light heads from a single phase state machine. Both approaches can never show left or green at the same time. The block also adds actuated protected-left phases and an emergency pre-emption that clears through yellow and all-red. It replaces the pair of free-running per-approach light FSMs with one arbiter that owns the right-of-way.

## Interface
Parameters:
- LEFT_T, 5: cycles in a protected-left phase (≥1)
- GREEN_T, 10: cycles in a green phase (≥1)
- YEL_T, 3: cycles in a yellow phase (≥1)
- ALLRED_T, 2: cycles in an all-red clearance phase (≥1)
- CW, 5: phase counter width; every *_T must be ≤ 2^CW

Ports:
- clock  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- emergency  in  1  level pre-emption request, sampled at posedge clock
- left_req_ns  in  1  NS left-turn sensor, level, sampled each cycle
- left_req_ew  in  1  EW left-turn sensor, level, sampled each cycle
- ns_out  out  4  NS head {left, green, yellow, red}: left=1001, green=0100, yellow=0010, red=0001
- ew_out  out  4  EW head, same encoding as ns_out
- phase  out  4  current state code (see Operation)
- emergency_ack  out  1  high while in ESTOP

## Operation
States and codes:
- ALLRED = 0
- NS_LEFT = 1
- NS_GREEN = 2
- NS_YEL = 3
- EW_LEFT = 4
- EW_GREEN = 5
- EW_YEL = 6
- ESTOP = 7
- The encoding is fixed because verification checks phase against it.

Outputs per state:
- The served approach shows the head for the state (left, green or yellow).
- The other approach shows red (0001).
- ALLRED and ESTOP: both heads 0001.

Internal registers:
- cnt[CW-1:0]: phase counter.
- served: the approach whose sequence ran most recently. 0 = NS, 1 = EW.
- pend_ns, pend_ew: latched left requests.

Normal sequence:
- A phase lasts exactly its *_T cycles: cnt counts 0..T-1, then the state advances and cnt returns to 0.
- ALLRED → the approach opposite to served. served toggles on this transition.
- If that approach's pend bit is set, go to X_LEFT, then X_GREEN. Otherwise go directly to X_GREEN.
- X_GREEN → X_YEL → ALLRED.

Left-request latching:
- pend_x is set on any cycle where left_req_x=1.
- pend_x is cleared on the cycle the FSM enters X_LEFT. If set and clear occur in the same cycle, clear wins.

Emergency (a sampled emergency=1 overrides the normal next-state):
- From X_LEFT or X_GREEN: go to X_YEL with cnt=0. The full YEL_T runs, then the FSM goes to ESTOP instead of ALLRED.
- In X_YEL: the yellow continues without restarting, then goes to ESTOP.
- From ALLRED: go to ESTOP immediately.
- ESTOP holds while emergency=1, with cnt held at 0.
- When emergency returns to 0: go to ALLRED for the full ALLRED_T, then resume normally. The approach opposite to served gets the next sequence.
- If emergency is deasserted during the yellow clear, the yellow still completes. The FSM then takes the normal path to ALLRED; ESTOP is not entered.
- Pending left requests are kept across an emergency.

## Timing
- All outputs are registered and decoded from the state register. There is no combinational path from inputs to outputs.
- State changes one cycle after the deciding posedge.
- Input-to-head latency:
  - emergency seen in green: heads turn yellow on the next cycle.
  - Both heads are red at most YEL_T+1 cycles after emergency is first sampled high.
- Asynchronous reset, at any time including mid-phase or during ESTOP, forces immediately:
  - state ALLRED, phase=0
  - cnt=0
  - served=1, so NS is served first
  - pend_ns=pend_ew=0
  - ns_out=ew_out=0001
  - emergency_ack=0
- Reset release: the first ALLRED lasts ALLRED_T cycles counted from the first posedge after reset_n rises.
- Invariant, every cycle: at most one of ns_out, ew_out is non-red.
- Invariant: a left or green on one approach is never followed directly by a non-red head on the other approach without passing through yellow and then ALLRED or ESTOP.

## Test plan
- Reset, no requests, default parameters → phase sequence 0(2) 2(10) 3(3) 0(2) 5(10) 6(3), repeating. Head values per Operation. served order NS first.
- left_req_ew pulsed for 1 cycle during NS_GREEN → next EW sequence is EW_LEFT(5) ew_out=1001, then EW_GREEN(10). pend_ew clears on entry. The following EW sequence skips the left phase.
- emergency raised at cycle 4 of NS_GREEN and held 20 cycles → ns_out=0010 for 3 cycles, then ESTOP with emergency_ack=1 and both heads 0001. After release: ALLRED(2), then EW_GREEN.
- emergency held for 1 cycle during NS_GREEN → NS_YEL(3), then ALLRED(2), then EW_GREEN; ESTOP is never entered. emergency during ALLRED → ESTOP on the next cycle.
- reset_n asserted mid-EW_GREEN with pend_ns set → outputs become 0001/0001 and phase=0 immediately, without waiting for a clock edge. After release, NS_GREEN is entered (no left, because pend_ns was cleared) after 2 cycles.
- Randomised requests and emergency over 10k cycles → the two invariants hold on every cycle. Every phase duration matches its parameter except the truncated green/left phases caused by pre-emption.

Source files
------------

// File: rtl/intersection_controller.sv
// Two-approach intersection sequencer (north-south / east-west).
// One phase FSM owns right-of-way for both heads, adds actuated protected-left
// phases and an emergency pre-emption that clears through yellow and all-red.
//
// Ports:
//   clock          system clock, rising edge
//   reset_n        asynchronous active-low reset
//   emergency      level pre-emption request
//   left_req_ns    NS left-turn sensor (level)
//   left_req_ew    EW left-turn sensor (level)
//   ns_out         NS head {left, green, yellow, red}
//   ew_out         EW head, same encoding
//   phase          current state code
//   emergency_ack  high while in ESTOP
module intersection_controller #(
  parameter int unsigned LEFT_T   = 5,
  parameter int unsigned GREEN_T  = 10,
  parameter int unsigned YEL_T    = 3,
  parameter int unsigned ALLRED_T = 2,
  parameter int unsigned CW       = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       emergency,
  input  logic       left_req_ns,
  input  logic       left_req_ew,
  output logic [3:0] ns_out,
  output logic [3:0] ew_out,
  output logic [3:0] phase,
  output logic       emergency_ack
);

  localparam logic [3:0] HEAD_LEFT  = 4'b1001;
  localparam logic [3:0] HEAD_GREEN = 4'b0100;
  localparam logic [3:0] HEAD_YEL   = 4'b0010;
  localparam logic [3:0] HEAD_RED   = 4'b0001;

  typedef enum logic [3:0] {
    S_ALLRED   = 4'd0,
    S_NS_LEFT  = 4'd1,
    S_NS_GREEN = 4'd2,
    S_NS_YEL   = 4'd3,
    S_EW_LEFT  = 4'd4,
    S_EW_GREEN = 4'd5,
    S_EW_YEL   = 4'd6,
    S_ESTOP    = 4'd7
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          served_q, served_d;
  logic          pend_ns_q, pend_ns_d;
  logic          pend_ew_q, pend_ew_d;
  logic [3:0]    ns_d, ew_d;
  logic          ack_d;
  logic          phase_end;

  // Final counter value of each timed phase.
  function automatic logic [CW-1:0] last_cnt(input state_t s);
    case (s)
      S_NS_LEFT,  S_EW_LEFT:  last_cnt = CW'(LEFT_T - 1);
      S_NS_GREEN, S_EW_GREEN: last_cnt = CW'(GREEN_T - 1);
      S_NS_YEL,   S_EW_YEL:   last_cnt = CW'(YEL_T - 1);
      S_ALLRED:               last_cnt = CW'(ALLRED_T - 1);
      default:                last_cnt = '0;
    endcase
  endfunction

  // State, counter, bookkeeping and registered head outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_ALLRED;
      cnt_q         <= '0;
      served_q      <= 1'b1;
      pend_ns_q     <= 1'b0;
      pend_ew_q     <= 1'b0;
      ns_out        <= HEAD_RED;
      ew_out        <= HEAD_RED;
      emergency_ack <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      served_q      <= served_d;
      pend_ns_q     <= pend_ns_d;
      pend_ew_q     <= pend_ew_d;
      ns_out        <= ns_d;
      ew_out        <= ew_d;
      emergency_ack <= ack_d;
    end
  end

  assign phase = state_q;

  // Next-state, counter, request latching and head decode of the next state.
  always_comb begin
    state_d   = state_q;
    served_d  = served_q;
    pend_ns_d = pend_ns_q | left_req_ns;
    pend_ew_d = pend_ew_q | left_req_ew;
    phase_end = (cnt_q == last_cnt(state_q));
    cnt_d     = phase_end ? '0 : cnt_q + CW'(1);
    ns_d      = HEAD_RED;
    ew_d      = HEAD_RED;
    ack_d     = 1'b0;

    case (state_q)
      S_ALLRED: begin
        if (emergency) begin
          state_d = S_ESTOP;
          cnt_d   = '0;
        end else if (phase_end) begin
          // Hand right-of-way to the approach not served last.
          served_d = ~served_q;
          if (served_q) state_d = pend_ns_q ? S_NS_LEFT : S_NS_GREEN;
          else          state_d = pend_ew_q ? S_EW_LEFT : S_EW_GREEN;
        end
      end
      S_NS_LEFT, S_NS_GREEN: begin
        if (emergency) begin
          state_d = S_NS_YEL;
          cnt_d   = '0;
        end else if (phase_end) begin
          state_d = (state_q == S_NS_LEFT) ? S_NS_GREEN : S_NS_YEL;
        end
      end
      S_EW_LEFT, S_EW_GREEN: begin
        if (emergency) begin
          state_d = S_EW_YEL;
          cnt_d   = '0;
        end else if (phase_end) begin
          state_d = (state_q == S_EW_LEFT) ? S_EW_GREEN : S_EW_YEL;
        end
      end
      S_NS_YEL, S_EW_YEL: begin
        // Yellow always completes; emergency at its end decides the exit.
        if (phase_end) state_d = emergency ? S_ESTOP : S_ALLRED;
      end
      S_ESTOP: begin
        cnt_d = '0;
        if (!emergency) state_d = S_ALLRED;
      end
      default: begin
        state_d = S_ALLRED;
        cnt_d   = '0;
      end
    endcase

    // A latched left request is consumed when its left phase starts.
    if (state_d == S_NS_LEFT && state_q != S_NS_LEFT) pend_ns_d = 1'b0;
    if (state_d == S_EW_LEFT && state_q != S_EW_LEFT) pend_ew_d = 1'b0;

    case (state_d)
      S_NS_LEFT:  ns_d = HEAD_LEFT;
      S_NS_GREEN: ns_d = HEAD_GREEN;
      S_NS_YEL:   ns_d = HEAD_YEL;
      S_EW_LEFT:  ew_d = HEAD_LEFT;
      S_EW_GREEN: ew_d = HEAD_GREEN;
      S_EW_YEL:   ew_d = HEAD_YEL;
      default: begin
        ns_d = HEAD_RED;
        ew_d = HEAD_RED;
      end
    endcase
    ack_d = (state_d == S_ESTOP);
  end

endmodule

// File: tb/tb_intersection_controller.sv
// Bench for intersection_controller: directed scenarios with literal phase
// run-length expectations, then randomized requests/emergency, all checked
// every cycle against a rule-level model of the intersection.
module tb_intersection_controller;

  localparam int LEFT_T   = 5;
  localparam int GREEN_T  = 10;
  localparam int YEL_T    = 3;
  localparam int ALLRED_T = 2;

  logic       clock;
  logic       reset_n;
  logic       emergency;
  logic       left_req_ns;
  logic       left_req_ew;
  logic [3:0] ns_out;
  logic [3:0] ew_out;
  logic [3:0] phase;
  logic       emergency_ack;

  intersection_controller #(
    .LEFT_T(LEFT_T), .GREEN_T(GREEN_T), .YEL_T(YEL_T), .ALLRED_T(ALLRED_T), .CW(5)
  ) dut (
    .clock(clock), .reset_n(reset_n), .emergency(emergency),
    .left_req_ns(left_req_ns), .left_req_ew(left_req_ew),
    .ns_out(ns_out), .ew_out(ew_out), .phase(phase), .emergency_ack(emergency_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Rule-level model: phase number, cycles already spent in it, who was served.
  int m_ph, m_age, m_nxt, m_base, m_kind;
  bit m_fin, m_served, m_pend_ns, m_pend_ew;

  function automatic int dur(input int ph);
    case (ph)
      0:       return ALLRED_T;
      1, 4:    return LEFT_T;
      2, 5:    return GREEN_T;
      3, 6:    return YEL_T;
      default: return 1 << 30;
    endcase
  endfunction

  function automatic logic [3:0] exp_head(input int ph, input int app);
    if (ph < 1 || ph > 6) return 4'b0001;
    if ((ph - 1) / 3 != app) return 4'b0001;
    case ((ph - 1) % 3)
      0:       return 4'b1001;
      1:       return 4'b0100;
      default: return 4'b0010;
    endcase
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_ph = 0; m_age = 0; m_served = 1'b1; m_pend_ns = 1'b0; m_pend_ew = 1'b0;
    end else begin
      m_fin = (m_age + 1 >= dur(m_ph));
      m_nxt = m_ph;
      if (m_ph == 7) begin
        m_nxt = emergency ? 7 : 0;
      end else if (m_ph == 0) begin
        if (emergency) m_nxt = 7;
        else if (m_fin) begin
          m_served = !m_served;
          if (m_served) m_nxt = m_pend_ew ? 4 : 5;
          else          m_nxt = m_pend_ns ? 1 : 2;
        end
      end else begin
        m_base = (m_ph >= 4) ? 4 : 1;
        m_kind = m_ph - m_base;
        if (m_kind < 2 && emergency) m_nxt = m_base + 2;
        else if (m_fin) m_nxt = (m_kind == 2) ? (emergency ? 7 : 0) : m_ph + 1;
      end
      m_pend_ns = m_pend_ns | left_req_ns;
      m_pend_ew = m_pend_ew | left_req_ew;
      if (m_nxt != m_ph && m_nxt == 1) m_pend_ns = 1'b0;
      if (m_nxt != m_ph && m_nxt == 4) m_pend_ew = 1'b0;
      m_age = (m_nxt == m_ph) ? m_age + 1 : 0;
      m_ph  = m_nxt;
    end
  end

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit nonred(input logic [3:0] h);
    return h != 4'b0001;
  endfunction

  function automatic bit is_go(input logic [3:0] h);
    return h == 4'b1001 || h == 4'b0100;
  endfunction

  logic [3:0] prev_ns = 4'b0001;
  logic [3:0] prev_ew = 4'b0001;

  // Per-cycle comparison of DUT against model plus the safety invariants.
  task automatic check_cycle();
    bit ok;
    chk4("phase", phase, 4'(m_ph));
    chk4("ns_out", ns_out, exp_head(m_ph, 0));
    chk4("ew_out", ew_out, exp_head(m_ph, 1));
    chk4("ack", {3'b0, emergency_ack}, {3'b0, m_ph == 7});
    ok = !(nonred(ns_out) && nonred(ew_out));
    ok &= !(nonred(prev_ns) && nonred(ew_out));
    ok &= !(nonred(prev_ew) && nonred(ns_out));
    ok &= !(is_go(prev_ns) && !(is_go(ns_out) || ns_out == 4'b0010));
    ok &= !(is_go(prev_ew) && !(is_go(ew_out) || ew_out == 4'b0010));
    ok &= !(prev_ns == 4'b0010 && is_go(ns_out));
    ok &= !(prev_ew == 4'b0010 && is_go(ew_out));
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL invariant actual ns=%b ew=%b prev ns=%b ew=%b t=%0t",
               ns_out, ew_out, prev_ns, prev_ew, $time);
    end
    prev_ns = ns_out;
    prev_ew = ew_out;
  endtask

  int rec[$];
  int exp_ph[$];
  int exp_len[$];

  // Check current cycle, record phase, drive inputs sampled at the next posedge.
  task automatic step(input bit e, input bit ln, input bit le);
    check_cycle();
    rec.push_back(int'(phase));
    emergency   = e;
    left_req_ns = ln;
    left_req_ew = le;
    @(negedge clock);
  endtask

  task automatic add_run(input int p, input int l);
    exp_ph.push_back(p);
    exp_len.push_back(l);
  endtask

  // Compare run-length encoding of recorded phases with the expected runs.
  task automatic check_runs(input string name);
    int rp[$];
    int rl[$];
    foreach (rec[i]) begin
      if (rp.size() != 0 && rp[rp.size() - 1] == rec[i]) rl[rl.size() - 1]++;
      else begin
        rp.push_back(rec[i]);
        rl.push_back(1);
      end
    end
    chki({name, "_nruns"}, rp.size(), exp_ph.size());
    for (int i = 0; i < exp_ph.size() && i < rp.size(); i++) begin
      chki($sformatf("%s_run%0d_phase", name, i), rp[i], exp_ph[i]);
      chki($sformatf("%s_run%0d_len", name, i), rl[i], exp_len[i]);
    end
    rec.delete();
    exp_ph.delete();
    exp_len.delete();
  endtask

  int em_left;

  initial begin
    reset_n = 1'b0; emergency = 1'b0; left_req_ns = 1'b0; left_req_ew = 1'b0;
    repeat (2) @(negedge clock);
    chk4("rst_phase", phase, 4'd0);
    chk4("rst_ns", ns_out, 4'b0001);
    chk4("rst_ew", ew_out, 4'b0001);
    chk4("rst_ack", {3'b0, emergency_ack}, 4'd0);
    reset_n = 1'b1;

    // Idle cycle: NS first, no lefts.
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b0);
    add_run(0, 2); add_run(2, 10); add_run(3, 3); add_run(0, 2); add_run(5, 10); add_run(6, 3);
    check_runs("idle");

    // EW left request pulsed in NS green; served once, then skipped.
    for (int i = 0; i < 62; i++) step(1'b0, 1'b0, i == 5);
    add_run(0, 2); add_run(2, 10); add_run(3, 3); add_run(0, 2); add_run(4, 5); add_run(5, 10);
    add_run(6, 3); add_run(0, 2); add_run(2, 10); add_run(3, 3); add_run(0, 2); add_run(5, 10);
    check_runs("ewleft");

    // Emergency at cycle 4 of NS green, held 20 cycles.
    for (int i = 0; i < 40; i++) begin
      if (i == 20) begin
        chk4("estop_ack", {3'b0, emergency_ack}, 4'd1);
        chk4("estop_ns", ns_out, 4'b0001);
        chk4("estop_ew", ew_out, 4'b0001);
      end
      if (i == 11) chk4("clear_ns_yel", ns_out, 4'b0010);
      step(i >= 9 && i <= 28, 1'b0, 1'b0);
    end
    add_run(6, 3); add_run(0, 2); add_run(2, 5); add_run(3, 3); add_run(7, 17); add_run(0, 2);
    add_run(5, 8);
    check_runs("emer_hold");

    // One-cycle emergency in NS green: yellow then normal all-red, no ESTOP.
    for (int i = 0; i < 25; i++) step(i == 9, 1'b0, 1'b0);
    add_run(5, 2); add_run(6, 3); add_run(0, 2); add_run(2, 3); add_run(3, 3); add_run(0, 2);
    add_run(5, 10);
    check_runs("emer_pulse");

    // Emergency in all-red enters ESTOP immediately.
    for (int i = 0; i < 10; i++) step(i == 3, 1'b0, 1'b0);
    add_run(6, 3); add_run(0, 1); add_run(7, 1); add_run(0, 2); add_run(2, 3);
    check_runs("emer_allred");

    // Latch an NS left request, then reset mid EW green.
    for (int i = 0; i < 15; i++) step(1'b0, i == 0, 1'b0);
    add_run(2, 7); add_run(3, 3); add_run(0, 2); add_run(5, 3);
    check_runs("pre_reset");
    chk4("pre_reset_phase", phase, 4'd5);
    #2 reset_n = 1'b0;
    #1;
    chk4("async_phase", phase, 4'd0);
    chk4("async_ns", ns_out, 4'b0001);
    chk4("async_ew", ew_out, 4'b0001);
    chk4("async_ack", {3'b0, emergency_ack}, 4'd0);
    prev_ns = 4'b0001;
    prev_ew = 4'b0001;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    add_run(0, 2); add_run(2, 3);
    check_runs("post_reset");

    // Randomized requests and emergency bursts.
    em_left = 0;
    for (int i = 0; i < 10000; i++) begin
      if (em_left == 0 && $urandom_range(0, 199) == 0) em_left = int'($urandom_range(1, 25));
      step(em_left > 0, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
      if (em_left > 0) em_left--;
    end
    rec.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
